// File: rtl/aes128_rd_sched.sv
// CCI-P c0 read-request scheduler for one AES-128 job: the key line first, then num_lines source lines.
// Optional stall-cycle statistics are built when AES128_RD_SCHED_STATS_EN is defined.
module aes128_rd_sched #(
  parameter int MAX_OUTSTANDING = 32,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [41:0]      key_addr,
  input  logic [41:0]      src_addr,
  input  logic [CNT_W-1:0] num_lines,
  input  logic             almfull,
  input  logic             stall,
  output logic             rd_valid,
  output logic [41:0]      rd_addr,
  output logic [15:0]      rd_mdata,
  input  logic             rsp_valid,
  input  logic [15:0]      rsp_mdata,
  output logic             key_loaded,
  output logic             busy,
  output logic             done,
  output logic [31:0]      stat_stall_cycles
);

  localparam int OUT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_KEY, S_WAIT_KEY, S_FETCH, S_DRAIN, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [41:0]      key_q, src_q;
  logic [CNT_W-1:0] lines_q, issued;
  logic [OUT_W-1:0] outstanding;

  logic start_acc, more, room, data_rsp, key_rsp, issue_key, issue_data;

  // Only the key flag of the response tag matters here; the index is for the datapath.
  logic unused_tag;
  assign unused_tag = ^rsp_mdata[14:0];

  always_comb begin
    start_acc  = (state == S_IDLE) && start;
    more       = issued < lines_q;
    room       = outstanding < OUT_W'(MAX_OUTSTANDING);
    data_rsp   = rsp_valid && !rsp_mdata[15];
    key_rsp    = (state == S_WAIT_KEY) && rsp_valid && rsp_mdata[15];
    issue_key  = (state == S_FETCH_KEY) && !almfull;
    issue_data = (state == S_FETCH) && !almfull && !stall && room && more;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_FETCH_KEY;
      S_FETCH_KEY: if (issue_key) state_nxt = S_WAIT_KEY;
      S_WAIT_KEY:  if (key_rsp) state_nxt = (lines_q == '0) ? S_DONE : S_FETCH;
      S_FETCH: begin
        if (issue_data && (issued + CNT_W'(1) == lines_q)) state_nxt = S_DRAIN;
        else if (!more) state_nxt = S_DRAIN;
      end
      // A response landing this cycle has not yet been subtracted from outstanding.
      S_DRAIN:     if ((outstanding == '0) && !data_rsp) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rd_valid    <= 1'b0;
      rd_addr     <= '0;
      rd_mdata    <= '0;
      key_loaded  <= 1'b0;
      done        <= 1'b0;
      key_q       <= '0;
      src_q       <= '0;
      lines_q     <= '0;
      issued      <= '0;
      outstanding <= '0;
    end else begin
      state      <= state_nxt;
      rd_valid   <= issue_key || issue_data;
      key_loaded <= key_rsp;
      done       <= (state == S_DONE);
      if (issue_key) begin
        rd_addr  <= key_q;
        rd_mdata <= 16'h8000;
      end else if (issue_data) begin
        rd_addr  <= src_q + 42'(issued);
        rd_mdata <= {1'b0, issued[14:0]};
      end
      if (start_acc) begin
        key_q       <= key_addr;
        src_q       <= src_addr;
        lines_q     <= num_lines;
        issued      <= '0;
        outstanding <= '0;
      end else begin
        if (issue_data) issued <= issued + CNT_W'(1);
        if (state != S_IDLE) begin
          if (issue_data && !data_rsp)
            outstanding <= outstanding + OUT_W'(1);
          else if (!issue_data && data_rsp && (outstanding != '0))
            outstanding <= outstanding - OUT_W'(1);
        end
      end
    end
  end

  assign busy = (state != S_IDLE);

`ifdef AES128_RD_SCHED_STATS_EN
  logic [31:0] stat_q;
  logic        stall_cyc;
  assign stall_cyc = (state == S_FETCH) && more && !issue_data;

  always_ff @(posedge clk) begin
    if (reset || start_acc)             stat_q <= '0;
    else if (stall_cyc && (stat_q != '1)) stat_q <= stat_q + 32'd1;
  end
  assign stat_stall_cycles = stat_q;
`else
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_aes128_rd_sched.sv
// Randomized self-checking bench for aes128_rd_sched: a transaction-level responder plus rule checks.
module tb_aes128_rd_sched;
  localparam int MAX_OUT = 3;

  logic        clk = 1'b0;
  logic        reset, start, almfull, stall, rsp_valid;
  logic [41:0] key_addr, src_addr, rd_addr;
  logic [31:0] num_lines, stat_stall_cycles;
  logic [15:0] rd_mdata, rsp_mdata;
  logic        rd_valid, key_loaded, busy, done;

  always #5 clk = ~clk;

  aes128_rd_sched #(.MAX_OUTSTANDING(MAX_OUT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .key_addr(key_addr), .src_addr(src_addr),
    .num_lines(num_lines), .almfull(almfull), .stall(stall), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .rd_mdata(rd_mdata), .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata),
    .key_loaded(key_loaded), .busy(busy), .done(done), .stat_stall_cycles(stat_stall_cycles)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { int due; logic [15:0] tag; } pend_t;
  pend_t       pend[$];
  logic [41:0] d_addr[$];
  logic [15:0] d_tag[$];
  int          d_cyc[$];
  int          cyc = 0;
  int          key_cnt, key_cyc, kl_cnt, kl_cyc, done_cnt, done_cyc, key_rsp_cyc, last_rsp_cyc;
  logic [41:0] k_addr;
  logic [15:0] k_tag;
  int          model_out = 0, kdly = 2, ddly = 2, start_cyc = 0;
  bit          job_on = 0, hold_data = 0;

  // One clock: record what the DUT did at this edge, judge it against the inputs of the
  // cycle that produced the decision, then choose the response for the new cycle.
  task automatic tick();
    logic pv, pa, ps;
    logic [15:0] pm;
    int out_dec;
    bit dreq, drsp;
    pv = rsp_valid; pm = rsp_mdata; pa = almfull; ps = stall; out_dec = model_out;
    @(posedge clk); #1; cyc++;
    drsp = job_on && pv && !pm[15];
    if (pv && pm[15]) key_rsp_cyc = cyc - 1;
    if (drsp) last_rsp_cyc = cyc - 1;
    dreq = rd_valid && !rd_mdata[15];
    if (rd_valid) begin
      if (rd_mdata[15]) begin
        key_cnt++; k_addr = rd_addr; k_tag = rd_mdata; key_cyc = cyc;
        chk("key_almfull", pa, 0);
        pend.push_back('{cyc + kdly, rd_mdata});
      end else begin
        d_addr.push_back(rd_addr); d_tag.push_back(rd_mdata); d_cyc.push_back(cyc);
        chk("data_throttle", {pa, ps}, 0);
        chk("data_limit", out_dec < MAX_OUT, 1);
        pend.push_back('{cyc + ddly, rd_mdata});
      end
    end
    if (dreq && !drsp) model_out++;
    else if (drsp && !dreq && model_out > 0) model_out--;
    if (key_loaded) begin kl_cnt++; kl_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; job_on = 0; end
    rsp_valid = 1'b0; rsp_mdata = '0;
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].due <= cyc && (!hold_data || pend[i].tag[15])) begin
        rsp_valid = 1'b1; rsp_mdata = pend[i].tag; pend.delete(i); break;
      end
    end
  endtask

  task automatic rel_data();
    for (int i = 0; i < pend.size(); i++) begin
      if (!pend[i].tag[15]) begin
        rsp_valid = 1'b1; rsp_mdata = pend[i].tag; pend.delete(i); break;
      end
    end
  endtask

  task automatic clear_rec();
    d_addr.delete(); d_tag.delete(); d_cyc.delete();
    key_cnt = 0; kl_cnt = 0; done_cnt = 0;
    key_cyc = -100; kl_cyc = -100; done_cyc = -100; key_rsp_cyc = -100; last_rsp_cyc = -100;
  endtask

  task automatic start_job(input logic [41:0] k, input logic [41:0] s, input int n);
    key_addr = k; src_addr = s; num_lines = n; start = 1'b1;
    start_cyc = cyc; job_on = 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_dreq(input int n, input int budget);
    int b = 0;
    while (d_addr.size() < n && b < budget) begin tick(); b++; end
    if (d_addr.size() < n) chk("req_timeout", d_addr.size(), n);
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int b = 0;
    while (done_cnt == 0 && b < budget) begin
      if (rnd) begin
        almfull = ($urandom_range(0, 3) == 0);
        stall   = ($urandom_range(0, 3) == 0);
      end
      tick(); b++;
    end
    almfull = 1'b0; stall = 1'b0;
    if (done_cnt == 0) chk("done_timeout", done_cnt, 1);
  endtask

  // Expected request stream: one key line, then src+i (mod 2^42) tagged i, in order.
  task automatic check_job(input logic [41:0] k, input logic [41:0] s, input int n);
    logic [41:0] ea;
    logic [15:0] et;
    chk("key_count", key_cnt, 1);
    chk("key_addr", k_addr, k);
    chk("key_tag", k_tag, 16'h8000);
    chk("data_count", d_addr.size(), n);
    for (int i = 0; i < n && i < d_addr.size(); i++) begin
      ea = s + 42'(i);
      et = {1'b0, 15'(i)};
      chk("data_addr", d_addr[i], ea);
      chk("data_tag", d_tag[i], et);
    end
    chk("key_loaded_count", kl_cnt, 1);
    chk("key_loaded_time", kl_cyc, key_rsp_cyc + 1);
    chk("done_count", done_cnt, 1);
    chk("done_time", done_cyc, (n == 0) ? key_rsp_cyc + 2 : last_rsp_cyc + 3);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    logic [41:0] k, s;
    int n;
    reset = 1'b1; start = 1'b0; almfull = 1'b0; stall = 1'b0;
    rsp_valid = 1'b0; rsp_mdata = '0; key_addr = '0; src_addr = '0; num_lines = '0;
    clear_rec();
    repeat (3) tick();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_mdata", rd_mdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_key_loaded", key_loaded, 0);
    chk("rst_stat", stat_stall_cycles, 0);
    reset = 1'b0;
    tick();

    // Basic job
    clear_rec(); kdly = 10; ddly = 5;
    k = 42'({$urandom(), $urandom()}); s = 42'({$urandom(), $urandom()});
    start_job(k, s, 4);
    chk("busy_on", busy, 1);
    wait_done(300, 0);
    check_job(k, s, 4);

    // Zero lines: key read two cycles after start, done two cycles after its response
    clear_rec(); kdly = $urandom_range(0, 6);
    k = 42'({$urandom(), $urandom()});
    start_job(k, 42'h123, 0);
    wait_done(100, 0);
    check_job(k, 42'h123, 0);
    chk("zero_key_time", key_cyc, start_cyc + 2);

    // Address wrap
    clear_rec(); kdly = 3; ddly = 2;
    start_job(42'h55, 42'h3FF_FFFF_FFFF, 2);
    wait_done(100, 0);
    check_job(42'h55, 42'h3FF_FFFF_FFFF, 2);
    if (d_addr.size() == 2) chk("wrap_zero", d_addr[1], 0);

    // almfull for 6 cycles, then stall for 4, mid-job
    clear_rec(); kdly = 10; ddly = 0;
    k = 42'({$urandom(), $urandom()}); s = 42'({$urandom(), $urandom()});
    start_job(k, s, 16);
    wait_dreq(3, 100);
    almfull = 1'b1; repeat (6) tick();
    almfull = 1'b0; stall = 1'b1; repeat (4) tick();
    stall = 1'b0;
    wait_done(300, 0);
    check_job(k, s, 16);
`ifdef AES128_RD_SCHED_STATS_EN
    chk("stat_stall", stat_stall_cycles, 10);
`else
    chk("stat_off", stat_stall_cycles, 0);
`endif

    // Outstanding limit, simultaneous issue/response, start while busy
    begin
      int c;
      clear_rec(); kdly = 2; ddly = 4; hold_data = 1;
      k = 42'({$urandom(), $urandom()}); s = 42'({$urandom(), $urandom()});
      start_job(k, s, 8);
      wait_dreq(MAX_OUT, 100);
      repeat (8) tick();
      chk("limit_count", d_addr.size(), MAX_OUT);
      key_addr = ~k; src_addr = ~s; num_lines = 100; start = 1'b1;
      tick();
      start = 1'b0;
      rel_data(); c = cyc;
      tick(); tick();
      chk("release_one", d_addr.size(), MAX_OUT + 1);
      if (d_cyc.size() > MAX_OUT) chk("release_time", d_cyc[MAX_OUT], c + 2);
      repeat (6) tick();
      chk("release_one_hold", d_addr.size(), MAX_OUT + 1);
      rel_data(); tick();
      rel_data(); tick();
      repeat (6) tick();
      chk("simul_issue_rsp", d_addr.size(), MAX_OUT + 3);
      hold_data = 0;
      wait_done(300, 0);
      check_job(k, s, 8);
      repeat (5) tick();
      chk("single_done", done_cnt, 1);
    end

    // Reset mid-job with reads outstanding, then stale responses in idle
    clear_rec(); kdly = 2; ddly = 4; hold_data = 1;
    start_job(42'h77, 42'h1000, 8);
    wait_dreq(MAX_OUT, 100);
    repeat (2) tick();
    chk("pre_reset_out", model_out, MAX_OUT);
    reset = 1'b1;
    tick();
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_key_loaded", key_loaded, 0);
    chk("mid_rst_addr", rd_addr, 0);
    chk("mid_rst_stat", stat_stall_cycles, 0);
    reset = 1'b0; model_out = 0; job_on = 0;
    repeat (MAX_OUT) begin rel_data(); tick(); end
    repeat (4) tick();
    chk("stale_no_done", done_cnt, 0);
    chk("stale_idle", busy, 0);
    clear_rec();
    start_job(42'h99, 42'h2000, 5);
    wait_dreq(MAX_OUT, 100);
    repeat (6) tick();
    chk("post_reset_limit", d_addr.size(), MAX_OUT);
    hold_data = 0;
    wait_done(300, 0);
    check_job(42'h99, 42'h2000, 5);

    // Randomized jobs with random throttling and latencies
    for (int j = 0; j < 6; j++) begin
      clear_rec();
      kdly = $urandom_range(0, 6); ddly = $urandom_range(0, 8);
      n = $urandom_range(1, 20);
      k = 42'({$urandom(), $urandom()}); s = 42'({$urandom(), $urandom()});
      start_job(k, s, n);
      wait_done(2000, 1);
      check_job(k, s, n);
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
